bildausgabe: RTL and testbench

Scan-out engine on the HDMI side of the graphics card; the read-side partner of the Bildpuffer framebuffer. It generates 640x480@60 video timing on the 25 MHz pixel clock and drives x_data/y_data into the framebuffer's combinational read port. Each 160x120 source pixel is replicated 4x4. The returned 8-bit RGB332 pixel is expanded to RGB888 and presented with aligned hsync/vsync/de to the HDMI transmitter.

---
 rtl/bildausgabe.sv | 133 +++++++++++++
 tb/tb_bildausgabe.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bildausgabe.sv
// bildausgabe: 640x480@60 scan-out engine. Generates the video timing, reads the
// 160x120 RGB332 framebuffer with 4x4 pixel replication, and presents RGB888 with
// hsync/vsync/de aligned two clocks behind the counters.
`timescale 1ns/1ps
module bildausgabe #(
   parameter int H_ACTIVE     = 640,
   parameter int H_FP         = 16,
   parameter int H_SYNC       = 96,
   parameter int H_BP         = 48,
   parameter int V_ACTIVE     = 480,
   parameter int V_FP         = 10,
   parameter int V_SYNC       = 2,
   parameter int V_BP         = 33,
   parameter int SCALE_SHIFT  = 2,
   parameter int BITSPERPIXEL = 8
) (
   input  logic                    clk,
   input  logic                    reset_n,
   output logic [7:0]              x_data,
   output logic [7:0]              y_data,
   input  logic [BITSPERPIXEL-1:0] pixelData,
   output logic                    hsync,
   output logic                    vsync,
   output logic                    de,
   output logic [7:0]              red,
   output logic [7:0]              green,
   output logic [7:0]              blue,
   output logic                    vblank,
   output logic                    frame_start
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int CNT_W   = 12;

   localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
   localparam logic [CNT_W-1:0] H_ACT_C  = CNT_W'(H_ACTIVE);
   localparam logic [CNT_W-1:0] HS_BEGIN = CNT_W'(H_ACTIVE + H_FP);
   localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
   localparam logic [CNT_W-1:0] V_ACT_C  = CNT_W'(V_ACTIVE);
   localparam logic [CNT_W-1:0] VS_BEGIN = CNT_W'(V_ACTIVE + V_FP);
   localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

   // RGB332 -> RGB888 by repeating each channel's bits to fill 8 bits, so full
   // scale maps to 0xFF and zero maps to 0x00.
   function automatic logic [23:0] expand_rgb(input logic [BITSPERPIXEL-1:0] p);
      return {p[7:5], p[7:5], p[7:6],
              p[4:2], p[4:2], p[4:3],
              p[1:0], p[1:0], p[1:0], p[1:0]};
   endfunction

   logic [CNT_W-1:0] h_cnt;
   logic [CNT_W-1:0] v_cnt;
   logic             vld_p0, hs_p0, vs_p0, vb_p0, fs_p0;
   logic             vld_p1, hs_p1, vs_p1, vb_p1, fs_p1;
   logic [23:0]      rgb_p1;

   // Horizontal / vertical raster counters; the line counter steps at end of line.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         h_cnt <= '0;
         v_cnt <= '0;
      end else if (h_cnt == H_LAST) begin
         h_cnt <= '0;
         v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + CNT_W'(1);
      end else begin
         h_cnt <= h_cnt + CNT_W'(1);
      end
   end

   // ---- stage 0: timing flags decoded from the current counter state ----
   // Decode visible region, sync windows, blanking and frame origin.
   always_comb begin
      vld_p0 = (h_cnt < H_ACT_C) && (v_cnt < V_ACT_C);
      hs_p0  = !((h_cnt >= HS_BEGIN) && (h_cnt < HS_END));
      vs_p0  = !((v_cnt >= VS_BEGIN) && (v_cnt < VS_END));
      vb_p0  = (v_cnt >= V_ACT_C);
      fs_p0  = (h_cnt == '0) && (v_cnt == '0);
   end

   // ---- stage 1: framebuffer address issued, flags delayed alongside ----
   // Addresses park at 0 during blanking so the read port never sees out-of-range values.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         x_data <= '0;
         y_data <= '0;
         vld_p1 <= 1'b0;
         hs_p1  <= 1'b1;
         vs_p1  <= 1'b1;
         vb_p1  <= 1'b0;
         fs_p1  <= 1'b0;
      end else begin
         x_data <= vld_p0 ? 8'(h_cnt >> SCALE_SHIFT) : 8'd0;
         y_data <= vld_p0 ? 8'(v_cnt >> SCALE_SHIFT) : 8'd0;
         vld_p1 <= vld_p0;
         hs_p1  <= hs_p0;
         vs_p1  <= vs_p0;
         vb_p1  <= vb_p0;
         fs_p1  <= fs_p0;
      end
   end

   // Blank the colour outside the visible window.
   always_comb begin
      rgb_p1 = vld_p1 ? expand_rgb(pixelData) : 24'd0;
   end

   // ---- stage 2: returned pixel captured, all outputs mutually aligned ----
   // Register the colour together with the stage-1 copies of the timing flags.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         red         <= '0;
         green       <= '0;
         blue        <= '0;
         hsync       <= 1'b1;
         vsync       <= 1'b1;
         de          <= 1'b0;
         vblank      <= 1'b0;
         frame_start <= 1'b0;
      end else begin
         red         <= rgb_p1[23:16];
         green       <= rgb_p1[15:8];
         blue        <= rgb_p1[7:0];
         hsync       <= hs_p1;
         vsync       <= vs_p1;
         de          <= vld_p1;
         vblank      <= vb_p1;
         frame_start <= fs_p1;
      end
   end

endmodule

// File: tb/tb_bildausgabe.sv
// Scoreboard bench for bildausgabe. Horizontal timing is the real 800-clock line;
// the vertical timing is shortened to 24 lines (16 visible) so whole frames fit
// in a short run. Expected values are pushed per output cycle and compared by an
// independent monitor; frame/line statistics are measured by the monitor too.
`timescale 1ns/1ps
module tb_bildausgabe;

   localparam int HT    = 800;
   localparam int VA    = 16;
   localparam int VT    = 24;
   localparam int FRAME = HT * VT;           // 19200 clocks per frame
   localparam int MIDRST_CYC = 2 * FRAME + 10 * HT + 300;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic [7:0] x_data, y_data, pixelData, red, green, blue, pix00;
   logic       hsync, vsync, de, vblank, frame_start;

   always #20 clk = ~clk;

   // Framebuffer model: pixel (0,0) is programmable, every other pixel is 0x5A.
   assign pixelData = (x_data == 8'd0 && y_data == 8'd0) ? pix00 : 8'h5A;

   bildausgabe #(
      .H_ACTIVE(640), .H_FP(16), .H_SYNC(96), .H_BP(48),
      .V_ACTIVE(VA), .V_FP(2), .V_SYNC(2), .V_BP(4),
      .SCALE_SHIFT(2), .BITSPERPIXEL(8)
   ) dut (
      .clk(clk), .reset_n(reset_n), .x_data(x_data), .y_data(y_data),
      .pixelData(pixelData), .hsync(hsync), .vsync(vsync), .de(de),
      .red(red), .green(green), .blue(blue), .vblank(vblank),
      .frame_start(frame_start)
   );

   typedef struct {
      int          cyc;
      int          sig;
      logic [31:0] val;
   } exp_t;

   exp_t  exp_q[$];
   int    cyc;
   int    errors = 0;
   int    checks = 0;
   string names [10] = '{"de", "hsync", "vsync", "vblank", "frame_start",
                         "x_data", "y_data", "red", "green", "blue"};

   int de_len_q[$], hs_off_q[$], hs_len_q[$];
   int f_len_q[$], f_de_q[$], f_hs_q[$], f_vs_q[$], f_vb_q[$], vs_off_q[$];

   // Clock edges counted since reset release.
   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) cyc <= 0;
      else          cyc <= cyc + 1;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
      checks++;
      if (act !== exp_v) begin
         errors++;
         $display("FAIL %s @cyc %0d: got %0h, want %0h", name, cyc, act, exp_v);
      end
   endtask

   function automatic logic [31:0] actual(input int sig);
      case (sig)
         0: return {31'd0, de};
         1: return {31'd0, hsync};
         2: return {31'd0, vsync};
         3: return {31'd0, vblank};
         4: return {31'd0, frame_start};
         5: return {24'd0, x_data};
         6: return {24'd0, y_data};
         7: return {24'd0, red};
         8: return {24'd0, green};
         default: return {24'd0, blue};
      endcase
   endfunction

   task automatic push(input int c, input int sig, input logic [31:0] v);
      exp_t e;
      e.cyc = c; e.sig = sig; e.val = v;
      exp_q.push_back(e);
   endtask

   // Expected sync/de/vblank/frame_start at output cycle k (counter state k-2).
   task automatic push_timing(input int k);
      int s, h, v;
      s = k - 2;
      if (s < 0) begin
         push(k, 0, 0); push(k, 1, 1); push(k, 2, 1); push(k, 3, 0); push(k, 4, 0);
      end else begin
         h = s % HT; v = (s / HT) % VT;
         push(k, 0, (h < 640 && v < VA) ? 1 : 0);
         push(k, 1, (h >= 656 && h < 752) ? 0 : 1);
         push(k, 2, (v >= 18 && v < 20) ? 0 : 1);
         push(k, 3, (v >= VA) ? 1 : 0);
         push(k, 4, (h == 0 && v == 0) ? 1 : 0);
      end
   endtask

   // Value of pix00 while counter state s is being fetched.
   function automatic logic [7:0] pix00_at(input int s, input bit first);
      if (!first) return 8'h92;
      case (s / HT)
         0: return 8'hFF;
         1: return 8'hE0;
         2: return 8'h03;
         default: return 8'h92;
      endcase
   endfunction

   // Hand-expanded RGB888 for the pixel values this bench stores.
   function automatic logic [23:0] rgb_of(input logic [7:0] p);
      case (p)
         8'hFF: return 24'hFFFFFF;
         8'hE0: return 24'hFF0000;
         8'h03: return 24'h0000FF;
         8'h92: return 24'h9292AA;
         8'h5A: return 24'h49DBAA;
         default: return 24'hDEAD00;
      endcase
   endfunction

   // Expected address (state k-1) and colour (state k-2) at output cycle k.
   task automatic push_addr_rgb(input int k, input bit first);
      int s, h, v;
      logic [23:0] rgb;
      s = k - 1;
      h = s % HT; v = (s / HT) % VT;
      if (s >= 0 && h < 640 && v < VA) begin
         push(k, 5, h / 4); push(k, 6, v / 4);
      end else begin
         push(k, 5, 0); push(k, 6, 0);
      end
      s = k - 2;
      h = s % HT; v = (s / HT) % VT;
      rgb = 24'd0;
      if (s >= 0 && h < 640 && v < VA)
         rgb = rgb_of((h / 4 == 0 && v / 4 == 0) ? pix00_at(s, first) : 8'h5A);
      push(k, 7, rgb[23:16]); push(k, 8, rgb[15:8]); push(k, 9, rgb[7:0]);
   endtask

   task automatic check_reset(input string tag);
      check({tag, "_x_data"}, {24'd0, x_data}, 0);
      check({tag, "_y_data"}, {24'd0, y_data}, 0);
      check({tag, "_hsync"}, {31'd0, hsync}, 1);
      check({tag, "_vsync"}, {31'd0, vsync}, 1);
      check({tag, "_de"}, {31'd0, de}, 0);
      check({tag, "_rgb"}, {8'd0, red, green, blue}, 0);
      check({tag, "_vblank"}, {31'd0, vblank}, 0);
      check({tag, "_frame_start"}, {31'd0, frame_start}, 0);
   endtask

   // Returns 10 time units after the edge that brings cyc to target.
   task automatic wait_cyc(input int target);
      int n;
      n = 0;
      while (cyc < target && n < 100000) begin
         @(posedge clk); #1; n++;
      end
      check("wait_cyc_reached", cyc, target);
      #9;
   endtask

   // Monitor: pops scoreboard entries for the current cycle and gathers statistics.
   initial begin : monitor
      exp_t e;
      int   rise_c, hs_fall_c, fs_c, f_len, f_de, f_hs, f_vs, f_vb;
      bit   in_frame, pde, phs, pvs;
      rise_c = 0; hs_fall_c = 0; fs_c = 0; in_frame = 0; pde = 0; phs = 1; pvs = 1;
      f_len = 0; f_de = 0; f_hs = 0; f_vs = 0; f_vb = 0;
      forever begin
         @(negedge clk);
         if (!reset_n) begin
            in_frame = 0; pde = 0; phs = 1; pvs = 1;
            de_len_q.delete(); hs_off_q.delete(); hs_len_q.delete();
         end else begin
            while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
               e = exp_q.pop_front();
               check(names[e.sig], actual(e.sig), e.val);
            end
            if (de && !pde) rise_c = cyc;
            if (!de && pde) de_len_q.push_back(cyc - rise_c);
            if (!hsync && phs) begin
               hs_fall_c = cyc;
               hs_off_q.push_back(cyc - rise_c);
            end
            if (hsync && !phs) hs_len_q.push_back(cyc - hs_fall_c);
            if (frame_start) begin
               if (in_frame) begin
                  f_len_q.push_back(f_len); f_de_q.push_back(f_de); f_hs_q.push_back(f_hs);
                  f_vs_q.push_back(f_vs); f_vb_q.push_back(f_vb);
               end
               in_frame = 1; fs_c = cyc;
               f_len = 0; f_de = 0; f_hs = 0; f_vs = 0; f_vb = 0;
            end
            if (in_frame) begin
               f_len++;
               if (de) f_de++;
               if (!hsync && phs) f_hs++;
               if (!vsync) f_vs++;
               if (!vsync && pvs) vs_off_q.push_back(cyc - fs_c);
               if (vblank) f_vb++;
            end
            pde = de; phs = hsync; pvs = vsync;
         end
      end
   end

   // Stimulus.
   initial begin : stimulus
      pix00 = 8'hFF;
      reset_n = 1'b0;
      repeat (3) @(posedge clk);
      #10;
      check_reset("por");

      // Run into line 0, then reset asynchronously between clock edges.
      reset_n = 1'b1;
      wait_cyc(300);
      reset_n = 1'b0;
      #1;
      check_reset("midline");

      // Two full frames plus part of a third, timing checked every cycle.
      for (int k = 1; k < MIDRST_CYC; k++) begin
         push_timing(k);
         if (k < FRAME) push_addr_rgb(k, 1'b1);
      end
      @(posedge clk); #10;
      reset_n = 1'b1;
      wait_cyc(1 * HT - 50);  pix00 = 8'hE0;
      wait_cyc(2 * HT - 50);  pix00 = 8'h03;
      wait_cyc(3 * HT - 50);  pix00 = 8'h92;
      wait_cyc(MIDRST_CYC);

      check("line_stats_present", (de_len_q.size() >= 3 && hs_off_q.size() >= 3
                                   && hs_len_q.size() >= 3) ? 1 : 0, 1);
      for (int i = 0; i < 3 && i < de_len_q.size() && i < hs_off_q.size()
           && i < hs_len_q.size(); i++) begin
         check("line_de_len", de_len_q[i], 640);
         check("line_hsync_offset", hs_off_q[i], 656);
         check("line_hsync_len", hs_len_q[i], 96);
      end
      check("frames_completed", f_len_q.size(), 2);
      check("vsync_falls", vs_off_q.size(), 2);
      for (int i = 0; i < 2 && i < f_len_q.size() && i < vs_off_q.size(); i++) begin
         check("frame_period", f_len_q[i], FRAME);
         check("frame_de_cycles", f_de_q[i], 640 * VA);
         check("frame_hsync_pulses", f_hs_q[i], VT);
         check("frame_vsync_low", f_vs_q[i], 2 * HT);
         check("frame_vsync_offset", vs_off_q[i], 18 * HT);
         check("frame_vblank_cycles", f_vb_q[i], (VT - VA) * HT);
      end

      // Mid-frame reset at line 10, held for five clocks.
      reset_n = 1'b0;
      #1;
      check_reset("midframe");
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check_reset("held");
      end
      for (int k = 1; k < 1700; k++) begin
         push_timing(k);
         push_addr_rgb(k, 1'b0);
      end
      @(posedge clk); #10;
      reset_n = 1'b1;
      wait_cyc(1700);
      @(negedge clk); #1;
      check("scoreboard_drained", exp_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
